fib_seq_gen: RTL and testbench

//  Parametrised generalised-Fibonacci sequence engine: F0=seed0, F1=seed1, Fk=Fk-1+Fk-2 mod 2^WIDTH.

---
 rtl/fib_pkg.sv | 13 +
 rtl/fib_step.sv | 18 +
 rtl/fib_seq_gen.sv | 125 ++++++++++++
 tb/tb_fib_seq_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types for the generalised-Fibonacci engine: FSM state encoding and mode codes.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        EMIT
    } fib_state_t;

    localparam logic MODE_STREAM = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci step: WIDTH-bit wrapped sum of two terms plus the carry out of the top bit.
// Purely combinational, zero latency, no flow control.
module fib_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b};
    assign sum      = full_sum[WIDTH-1:0];
    assign carry    = full_sum[WIDTH];

endmodule

// File: rtl/fib_seq_gen.sv
// Generalised-Fibonacci engine: STREAM emits F0..Fn one beat/clock, SINGLE emits Fn after n+1 clocks.
// Beats hold stable while out_ready is low; start is ignored while busy, abort cancels without done.
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [IDX_W-1:0] n_idx,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             overflow
);

    fib_state_t       state, state_nxt;
    logic [WIDTH-1:0] a, b;
    logic [IDX_W-1:0] k;
    logic [IDX_W-1:0] n_q;
    logic             mode_q;

    logic             accept;
    logic             advance;
    logic             finish;

    logic [WIDTH-1:0] step_sum;
    logic             step_carry;
    logic [IDX_W:0]   j_next;
    logic             j_in_range;

    fib_step #(.WIDTH(WIDTH)) u_step (
        .a     (a),
        .b     (b),
        .sum   (step_sum),
        .carry (step_carry)
    );

    // Advancing from k produces F(k+2); only terms up to n may raise the flag.
    assign j_next     = {1'b0, k} + (IDX_W+1)'(2);
    assign j_in_range = (j_next <= {1'b0, n_q});

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = (mode == MODE_STREAM) ? EMIT : CALC;
                end
            end
            CALC: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (k == n_q) begin
                    state_nxt = EMIT;
                end else begin
                    advance = 1'b1;
                end
            end
            EMIT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    if ((k == n_q) || (mode_q == MODE_SINGLE)) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            k        <= '0;
            n_q      <= '0;
            mode_q   <= MODE_STREAM;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= finish;
            if (accept) begin
                a        <= seed0;
                b        <= seed1;
                k        <= '0;
                n_q      <= n_idx;
                mode_q   <= mode;
                overflow <= 1'b0;
            end else if (advance) begin
                a <= b;
                b <= step_sum;
                k <= k + 1'b1;
                if (step_carry && j_in_range) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == EMIT);
    assign out_data  = a;
    assign out_index = k;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen at WIDTH=8: SINGLE-mode vector table plus stream, stall, abort and reset sequences.
module tb_fib_seq_gen;

    localparam int WIDTH = 8;
    localparam int IDX_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             mode;
    logic [IDX_W-1:0] n_idx;
    logic [WIDTH-1:0] seed0;
    logic [WIDTH-1:0] seed1;
    logic             busy;
    logic             done;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDX_W-1:0] out_index;
    logic             overflow;

    fib_seq_gen #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .n_idx     (n_idx),
        .seed0     (seed0),
        .seed1     (seed1),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       mode;
        logic [7:0] n;
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] exp_data;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic m, input logic [7:0] n, input logic [7:0] s0, input logic [7:0] s1);
        mode  = m;
        n_idx = n;
        seed0 = s0;
        seed1 = s1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int e;
        int exp_lat;
        logic got_done;
        logic rdy;
        logic [7:0] fib_exp [8];
        logic [7:0] bp_exp [5];

        fib_exp = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13};
        bp_exp  = '{8'd3, 8'd4, 8'd7, 8'd11, 8'd18};

        //           mode  n      s0       s1       data     ovf
        vecs[0] = '{1'b1, 8'd5,  8'd2,   8'd1,   8'd11,  1'b0};
        vecs[1] = '{1'b1, 8'd13, 8'd0,   8'd1,   8'd233, 1'b0};
        vecs[2] = '{1'b1, 8'd14, 8'd0,   8'd1,   8'd121, 1'b1};
        vecs[3] = '{1'b1, 8'd0,  8'd7,   8'd9,   8'd7,   1'b0};
        vecs[4] = '{1'b1, 8'd1,  8'd7,   8'd9,   8'd9,   1'b0};
        vecs[5] = '{1'b1, 8'd2,  8'd200, 8'd100, 8'd44,  1'b1};
        vecs[6] = '{1'b1, 8'd1,  8'd200, 8'd100, 8'd100, 1'b0};
        vecs[7] = '{1'b1, 8'd7,  8'd0,   8'd1,   8'd13,  1'b0};
        vecs[8] = '{1'b0, 8'd0,  8'd42,  8'd5,   8'd42,  1'b0};

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        mode      = 1'b0;
        n_idx     = '0;
        seed0     = '0;
        seed1     = '0;
        out_ready = 1'b1;

        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", out_data, 0);
        chk("rst_index", out_index, 0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 9; v++) begin
            issue(vecs[v].mode, vecs[v].n, vecs[v].s0, vecs[v].s1);
            exp_lat = (vecs[v].mode == 1'b1) ? (int'(vecs[v].n) + 1) : 0;
            cyc = 0;
            while (!out_valid && cyc < 300) begin
                tick();
                cyc++;
            end
            chk($sformatf("vec%0d_latency", v), cyc, exp_lat);
            chk($sformatf("vec%0d_data", v), out_data, vecs[v].exp_data);
            chk($sformatf("vec%0d_index", v), out_index, vecs[v].n);
            chk($sformatf("vec%0d_ovf", v), overflow, vecs[v].exp_ovf);
            tick();
            chk($sformatf("vec%0d_done", v), done, 1);
            chk($sformatf("vec%0d_busy_after", v), busy, 0);
            tick();
            chk($sformatf("vec%0d_done_pulse", v), done, 0);
            chk($sformatf("vec%0d_ovf_held", v), overflow, vecs[v].exp_ovf);
        end

        // Full stream F0..F7 at one beat per clock
        issue(1'b0, 8'd7, 8'd0, 8'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stream_valid%0d", i), out_valid, 1);
            chk($sformatf("stream_data%0d", i), out_data, fib_exp[i]);
            chk($sformatf("stream_index%0d", i), out_index, i);
            tick();
        end
        chk("stream_done", done, 1);
        chk("stream_busy", busy, 0);
        chk("stream_ovf", overflow, 0);

        // Start in the same cycle as the done pulse is accepted
        issue(1'b1, 8'd0, 8'd5, 8'd6);
        chk("start_on_done_busy", busy, 1);
        tick();
        chk("start_on_done_valid", out_valid, 1);
        chk("start_on_done_data", out_data, 5);
        tick();
        chk("start_on_done_done", done, 1);
        tick();

        // Backpressure: ready high one cycle in three, plus a start while busy
        issue(1'b0, 8'd4, 8'd3, 8'd4);
        e = 0;
        got_done = 1'b0;
        for (int c = 0; c < 60 && !got_done; c++) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (out_valid) begin
                    chk($sformatf("bp_data_c%0d", c), out_data, (e < 5) ? bp_exp[e] : 8'hxx);
                    chk($sformatf("bp_index_c%0d", c), out_index, e);
                end
                rdy = ((c % 3) == 0);
                out_ready = rdy;
                if (out_valid && rdy) e++;
                if (c == 4) begin
                    mode  = 1'b1;
                    n_idx = 8'd1;
                    seed0 = 8'd100;
                    seed1 = 8'd100;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                tick();
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk("bp_got_done", got_done, 1);
        chk("bp_beats", e, 5);
        chk("bp_busy_after", busy, 0);
        tick();
        chk("bp_ignored_start", busy, 0);

        // Abort during the third stream beat
        issue(1'b0, 8'd7, 8'd0, 8'd1);
        tick();
        tick();
        chk("abort_at_beat", out_index, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick();
        chk("abort_no_done", done, 0);

        // Abort in CALC keeps a flag already raised
        issue(1'b1, 8'd5, 8'd200, 8'd100);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_calc_busy", busy, 0);
        chk("abort_calc_ovf", overflow, 1);

        // Abort and start together in IDLE: start dropped
        mode  = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        chk("abort_start_valid", out_valid, 0);

        // Asynchronous reset while a beat is stalled
        issue(1'b0, 8'd7, 8'd200, 8'd100);
        tick();
        out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_data", out_data, 100);
        chk("pre_rst_ovf", overflow, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_index", out_index, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_done", done, 0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_rst_done%0d", i), done, 0);
            chk($sformatf("post_rst_busy%0d", i), busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
